// File: rtl/adder_feeder_pkg.sv
// Shared types and helpers for the adder operand feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adder_feeder_pkg;

    typedef enum logic {
        FILL = 1'b0,
        PAD  = 1'b1
    } state_e;

    localparam int FRAME_CNT_W = 16;

    // Slot index width; a single-operand frame still needs one bit of counter.
    function automatic int slot_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_feeder_if.sv
// Stream-in / frame-out bundle between a word source, the feeder and the adder tree.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the stream side; the frame side has none.
interface adder_feeder_if #(
    parameter int bits = 8,
    parameter int num  = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [bits-1:0]       in_data;
    logic                  in_last;
    logic                  valid;
    logic [num*bits-1:0]   data;
    logic                  short_frame;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, valid, data, short_frame
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, valid, data, short_frame
    );
endinterface

// File: rtl/adder_feeder.sv
// Packs num stream words into one parallel operand frame; optional frame counters under ADDER_FEEDER_FRAME_CNT_EN.
// Latency: valid 1 cycle after the last word of a full frame, 2 cycles after in_last on a short frame.
// Backpressure: in_ready drops only for the single padding cycle; the frame output has no stall path.
module adder_feeder
    import adder_feeder_pkg::*;
#(
    parameter int bits = 8,
    parameter int num  = 32
)
(
    input  logic                   clk,
    input  logic                   rst,
    adder_feeder_if.slave          bus
`ifdef ADDER_FEEDER_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic [FRAME_CNT_W-1:0] short_cnt
`endif
);

    localparam int            CW   = slot_w(num);
    localparam logic [CW-1:0] LAST = CW'(num - 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [num*bits-1:0]   coll_q, coll_d;
    logic [num*bits-1:0]   data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  short_q, short_d;
    logic                  ready_q;
    logic                  accept;

    assign accept          = bus.in_valid & ready_q;
    assign bus.in_ready    = ready_q;
    assign bus.valid       = valid_q;
    assign bus.data        = data_q;
    assign bus.short_frame = short_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            coll_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            short_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            coll_q  <= coll_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            short_q <= short_d;
            // Registered so in_ready first rises on the edge after reset release.
            ready_q <= (state_d == FILL);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        coll_d  = coll_q;
        data_d  = data_q;
        valid_d = 1'b0;
        short_d = short_q;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    coll_d[int'(cnt_q)*bits +: bits] = bus.in_data;
                    // in_last on the final slot is just a full frame.
                    if (cnt_q == LAST) begin
                        data_d  = coll_d;
                        valid_d = 1'b1;
                        short_d = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (bus.in_last) begin
                            state_d = PAD;
                        end
                    end
                end
            end
            PAD: begin
                // cnt_q already points past the last written slot; everything from there up is stale.
                for (int k = 0; k < num; k++) begin
                    data_d[k*bits +: bits] = (CW'(k) < cnt_q) ? coll_q[k*bits +: bits] : '0;
                end
                valid_d = 1'b1;
                short_d = 1'b1;
                cnt_d   = '0;
                state_d = FILL;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

`ifdef ADDER_FEEDER_FRAME_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            short_cnt <= '0;
        end else if (valid_d) begin
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            if (short_d) begin
                short_cnt <= short_cnt + FRAME_CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_adder_feeder.sv
// Directed table-driven bench for adder_feeder (bits=8, num=32).
// Latency: n/a. Backpressure: n/a.
module tb_adder_feeder;

    localparam int B = 8;
    localparam int N = 32;

    typedef struct {
        int         n;
        logic [7:0] base;
        bit         use_last;
        bit         gaps;
        bit         pre_rst;
        bit         exp_short;
        int         exp_lat;
        logic [7:0] exp_sum;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adder_feeder_if #(.bits(B), .num(N)) bus ();

`ifdef ADDER_FEEDER_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    logic [15:0] short_cnt;
`endif

    adder_feeder #(.bits(B), .num(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef ADDER_FEEDER_FRAME_CNT_EN
        ,
        .frame_cnt (frame_cnt),
        .short_cnt (short_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int ready_drops = 0;

    logic [N*B-1:0] cap_data[$];
    bit             cap_short[$];
    int             cap_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            cap_data.push_back(bus.data);
            cap_short.push_back(bus.short_frame);
            cap_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Entered and left at a negedge; a word presented here is taken at the next posedge if in_ready.
    task automatic send_word(input logic [7:0] d, input bit last, input bit gap);
        int w;
        if (gap) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w > 0) ready_drops++;
        if (bus.in_ready !== 1'b1) begin
            check("in_ready wait timeout", {63'd0, bus.in_ready}, 64'd1);
        end
        acc_cyc = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [N*B-1:0] d, input int n,
                               input logic [7:0] base, input logic [7:0] exp_sum);
        int         bad;
        logic [7:0] a, e, s;
        bad = 0;
        s   = 8'h00;
        for (int k = 0; k < N; k++) begin
            a = d[k*B +: B];
            e = (k < n) ? base + 8'(k) : 8'h00;
            if (a !== e) bad++;
            s = s + a;
        end
        check({tag, " bad slots"}, 64'(bad), 64'd0);
        check({tag, " adder sum"}, {56'd0, s}, {56'd0, exp_sum});
    endtask

    initial begin
        vec_t           vecs[7];
        bit             r0, r1;
        int             w;
        logic [N*B-1:0] d;
        string          tag;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;

        //            n   base   last gaps prst short lat sum
        vecs[0] = '{32, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1, 8'h10};
        vecs[1] = '{ 5, 8'hA1, 1'b1, 1'b0, 1'b0, 1'b1, 2, 8'h2F};
        vecs[2] = '{32, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1, 8'h10};
        vecs[3] = '{32, 8'h40, 1'b0, 1'b0, 1'b1, 1'b0, 1, 8'hF0};
        vecs[4] = '{ 1, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b1, 2, 8'h7E};
        vecs[5] = '{32, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1, 8'h10};
        vecs[6] = '{ 3, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, 2, 8'hD3};

        repeat (3) @(negedge clk);
        check("reset valid", {63'd0, bus.valid}, 64'd0);
        check("reset data", 64'(bus.data), 64'd0);
        check("reset short_frame", {63'd0, bus.short_frame}, 64'd0);
        check("reset in_ready", {63'd0, bus.in_ready}, 64'd0);
        rst = 1'b0;
        #1 check("in_ready before first edge", {63'd0, bus.in_ready}, 64'd0);
        @(negedge clk);
        check("in_ready after release", {63'd0, bus.in_ready}, 64'd1);

        for (int i = 0; i < 7; i++) begin
            tag = $sformatf("v%0d", i);
            if (vecs[i].pre_rst) begin
                for (int k = 0; k < 10; k++) send_word(8'hEE, 1'b0, 1'b0);
                rst = 1'b1;
                #1;
                check({tag, " rst valid"}, {63'd0, bus.valid}, 64'd0);
                check({tag, " rst data"}, 64'(bus.data), 64'd0);
                check({tag, " rst in_ready"}, {63'd0, bus.in_ready}, 64'd0);
                repeat (3) @(negedge clk);
                check({tag, " no valid in reset"}, 64'(cap_data.size()), 64'd0);
                rst = 1'b0;
                @(negedge clk);
            end
            for (int k = 0; k < vecs[i].n; k++) begin
                send_word(vecs[i].base + 8'(k), vecs[i].use_last && (k == vecs[i].n - 1),
                          vecs[i].gaps ? bit'($urandom_range(0, 1)) : 1'b0);
            end
            r0 = bus.in_ready;
            @(negedge clk);
            r1 = bus.in_ready;
            w = 0;
            while (cap_data.size() == 0 && w < 8) begin
                @(negedge clk);
                w++;
            end
            check({tag, " valid seen"}, 64'(cap_data.size() > 0), 64'd1);
            if (cap_data.size() > 0) begin
                d = cap_data.pop_front();
                check({tag, " latency"}, 64'(cap_cyc.pop_front() - acc_cyc), 64'(vecs[i].exp_lat));
                check({tag, " short_frame"}, {63'd0, cap_short.pop_front()}, {63'd0, vecs[i].exp_short});
                check_frame(tag, d, vecs[i].n, vecs[i].base, vecs[i].exp_sum);
            end
            check({tag, " in_ready after last"}, {63'd0, r0}, {63'd0, !vecs[i].exp_short});
            check({tag, " in_ready restored"}, {63'd0, r1}, 64'd1);
            repeat (3) @(negedge clk);
            check({tag, " single pulse"}, 64'(cap_data.size()), 64'd0);
            cap_data.delete();
            cap_short.delete();
            cap_cyc.delete();
        end

        ready_drops = 0;
        for (int i = 0; i < 96; i++) send_word(8'(i), 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("b2b in_ready drops", 64'(ready_drops), 64'd0);
        check("b2b pulse count", 64'(cap_data.size()), 64'd3);
        if (cap_data.size() == 3) begin
            check("b2b spacing 0-1", 64'(cap_cyc[1] - cap_cyc[0]), 64'd32);
            check("b2b spacing 1-2", 64'(cap_cyc[2] - cap_cyc[1]), 64'd32);
            for (int f = 0; f < 3; f++) begin
                check_frame($sformatf("b2b f%0d", f), cap_data[f], 32, 8'(32 * f), 8'hF0);
                check($sformatf("b2b f%0d short", f), {63'd0, cap_short[f]}, 64'd0);
            end
        end

`ifdef ADDER_FEEDER_FRAME_CNT_EN
        // Counters were cleared by the reset ahead of v3: v3..v6 plus three back-to-back frames.
        check("frame_cnt", 64'(frame_cnt), 64'd7);
        check("short_cnt", 64'(short_cnt), 64'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
